inst_loader: RTL and testbench

//   UART bootloader that writes the instruction RAM the CPU fetches from.

---
 rtl/inst_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_inst_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// UART bootloader for the instruction RAM.
// Receives "A5, LEN_HI, LEN_LO, 4*N data bytes (MSB first), XOR checksum" on an
// 8N1 line, writes each assembled 32-bit word to the RAM write port, and keeps
// the CPU in reset until a frame completes with a matching checksum.
module inst_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              rx_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int BIT_CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0] HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CLKS);
  localparam logic [16:0]       LEN_MAX   = 17'(2 ** ADDR_W);
  localparam logic [7:0]        SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  // ---------------- UART receiver ----------------
  rx_state_t         rx_state;
  logic              rx_meta, rx_s, rx_q;
  logic [BIT_CW-1:0] bit_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        rx_sr;
  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              frame_err;

  // Synchronise rx_i, detect start edge, sample bits at their centres.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_q       <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_sr      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // this block samples the values from before the edge, like real hardware.
      rx_meta    <= rx_i;
      rx_s       <= rx_meta;
      rx_q       <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_q && !rx_s) begin
            rx_state <= RX_START;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            // Line back high at mid start bit means it was a glitch.
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            rx_sr   <= {rx_s, rx_sr[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt    <= '0;
            rx_byte    <= rx_sr;
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
            rx_state   <= RX_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Frame loader ----------------
  state_t           state;
  logic             start_q;
  logic [15:0]      len;
  logic [1:0]       byte_idx;
  logic [23:0]      word_sr;
  logic [7:0]       csum;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_frame;
  logic             abort;
  logic [16:0]      words_next;

  assign in_frame   = state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM};
  assign abort      = frame_err || (tmo_cnt == TMO_MAX);
  assign words_next = 17'(word_cnt_o) + 17'd1;

  // Frame parsing, word assembly, RAM strobes and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      len        <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      cpu_rst_o  <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      word_cnt_o <= '0;
    end else begin
      start_q  <= start_i;
      ram_we_o <= 1'b0;

      // Inter-byte gap counter, only meaningful once the header is seen.
      if (!in_frame || byte_valid) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;

      if (in_frame && abort) begin
        state <= S_ERR;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !start_q) begin
              state      <= S_SYNC;
              busy_o     <= 1'b1;
              cpu_rst_o  <= 1'b1;
              done_o     <= 1'b0;
              err_o      <= 1'b0;
              word_cnt_o <= '0;
            end
          end
          S_SYNC: begin
            if (byte_valid && rx_byte == SYNC_BYTE) state <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (byte_valid) begin
              len[15:8] <= rx_byte;
              state     <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (byte_valid) begin
              len      <= {len[15:8], rx_byte};
              byte_idx <= '0;
              csum     <= '0;
              if ({1'b0, len[15:8], rx_byte} > LEN_MAX) state <= S_ERR;
              else if ({len[15:8], rx_byte} == 16'd0)   state <= S_CSUM;
              else                                      state <= S_DATA;
            end
          end
          S_DATA: begin
            if (byte_valid) begin
              csum     <= csum ^ rx_byte;
              byte_idx <= byte_idx + 1'b1;
              word_sr  <= {word_sr[15:0], rx_byte};
              if (byte_idx == 2'd3) begin
                ram_we_o   <= 1'b1;
                ram_addr_o <= word_cnt_o[ADDR_W-1:0];
                ram_data_o <= {word_sr, rx_byte};
                state      <= S_WRITE;
              end
            end
          end
          S_WRITE: begin
            word_cnt_o <= word_cnt_o + 1'b1;
            state      <= (words_next == {1'b0, len}) ? S_CSUM : S_DATA;
          end
          S_CSUM: begin
            if (byte_valid) state <= (rx_byte == csum) ? S_DONE : S_ERR;
          end
          S_DONE: begin
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            cpu_rst_o <= 1'b0;
            state     <= S_IDLE;
          end
          S_ERR: begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: good load, bad checksum, sync hunting,
// oversize length, timeout, framing error, start-bit glitch, async abort.
module tb_inst_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_i = 1'b0;
  logic              rx_i = 1'b1;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_data_o;
  logic              cpu_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_cnt_o;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] w_addr[$];
  logic [31:0]       w_data[$];
  logic [7:0]        frame[$];

  inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .TIMEOUT_CLKS(2000)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rx_i(rx_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  // Record every RAM write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we_o) begin
      w_addr.push_back(ram_addr_o);
      w_data.push_back(ram_data_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int max_clks, input string tag);
    int n = 0;
    while (busy_o && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(tag, {31'd0, busy_o}, 32'd0);
  endtask

  // Builds A5, length, the 8-byte two-word payload and its XOR checksum.
  task automatic build_two_word(input logic [7:0] csum_flip);
    logic [7:0] d[8];
    logic [7:0] x;
    d = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    x = 8'h00;
    frame = {8'hA5, 8'h00, 8'h02};
    foreach (d[i]) begin
      frame.push_back(d[i]);
      x = x ^ d[i];
    end
    frame.push_back(x ^ csum_flip);
  endtask

  task automatic clear_writes();
    w_addr.delete();
    w_data.delete();
  endtask

  task automatic check_good_two_word(input string t);
    check({t, "_nwr"}, w_addr.size(), 2);
    if (w_addr.size() == 2) begin
      check({t, "_a0"}, 32'(w_addr[0]), 0);
      check({t, "_d0"}, w_data[0], 32'h12345678);
      check({t, "_a1"}, 32'(w_addr[1]), 1);
      check({t, "_d1"}, w_data[1], 32'h9ABCDEF0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we", {31'd0, ram_we_o}, 0);
    check("rst_addr", 32'(ram_addr_o), 0);
    check("rst_data", ram_data_o, 0);
    check("rst_cpu", {31'd0, cpu_rst_o}, 1);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_err", {31'd0, err_o}, 0);
    check("rst_cnt", 32'(word_cnt_o), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: good two-word load
    clear_writes();
    build_two_word(8'h00);
    pulse_start();
    check("t1_busy", {31'd0, busy_o}, 1);
    send_frame();
    wait_idle(400, "t1_idle");
    check_good_two_word("t1");
    check("t1_done", {31'd0, done_o}, 1);
    check("t1_err", {31'd0, err_o}, 0);
    check("t1_cpu", {31'd0, cpu_rst_o}, 0);
    check("t1_cnt", 32'(word_cnt_o), 2);

    // 7: bytes arriving while idle are ignored
    clear_writes();
    frame = {8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame();
    repeat (20) @(negedge clk);
    check("t7_busy", {31'd0, busy_o}, 0);
    check("t7_nwr", w_addr.size(), 0);
    check("t7_done", {31'd0, done_o}, 1);

    // 2: checksum mismatch
    clear_writes();
    build_two_word(8'h01);
    pulse_start();
    check("t2_done_clr", {31'd0, done_o}, 0);
    send_frame();
    wait_idle(400, "t2_idle");
    check_good_two_word("t2");
    check("t2_err", {31'd0, err_o}, 1);
    check("t2_done", {31'd0, done_o}, 0);
    check("t2_cpu", {31'd0, cpu_rst_o}, 1);

    // 3: junk before sync, zero-length image
    clear_writes();
    frame = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame();
    wait_idle(400, "t3_idle");
    check("t3_nwr", w_addr.size(), 0);
    check("t3_done", {31'd0, done_o}, 1);
    check("t3_err", {31'd0, err_o}, 0);
    check("t3_cnt", 32'(word_cnt_o), 0);

    // 4: length 1025 exceeds 1024-word RAM
    clear_writes();
    frame = {8'hA5, 8'h04, 8'h01};
    pulse_start();
    send_frame();
    wait_idle(400, "t4_idle");
    check("t4_err", {31'd0, err_o}, 1);
    check("t4_nwr", w_addr.size(), 0);

    // 5a: inter-byte timeout
    clear_writes();
    frame = {8'hA5, 8'h00, 8'h01, 8'h12};
    pulse_start();
    send_frame();
    repeat (1500) @(negedge clk);
    check("t5a_busy_mid", {31'd0, busy_o}, 1);
    wait_idle(3000, "t5a_idle");
    check("t5a_err", {31'd0, err_o}, 1);
    check("t5a_nwr", w_addr.size(), 0);

    // 5b: framing error in DATA
    pulse_start();
    send_frame();
    send_byte(8'h34, 1'b0);
    wait_idle(400, "t5b_idle");
    check("t5b_err", {31'd0, err_o}, 1);
    check("t5b_nwr", w_addr.size(), 0);

    // 5c: short low glitch in SYNC must not start a byte
    pulse_start();
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (6) @(negedge clk);
    frame = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_idle(400, "t5c_idle");
    check("t5c_done", {31'd0, done_o}, 1);
    check("t5c_err", {31'd0, err_o}, 0);

    // 6: async reset during the second word, then a clean reload
    clear_writes();
    build_two_word(8'h00);
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(frame[i]);
    check("t6_pre_nwr", w_addr.size(), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_we", {31'd0, ram_we_o}, 0);
    check("t6_addr", 32'(ram_addr_o), 0);
    check("t6_data", ram_data_o, 0);
    check("t6_cpu", {31'd0, cpu_rst_o}, 1);
    check("t6_busy", {31'd0, busy_o}, 0);
    check("t6_cnt", 32'(word_cnt_o), 0);
    clear_writes();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start();
    send_frame();
    wait_idle(400, "t6_idle");
    check_good_two_word("t6");
    check("t6_done", {31'd0, done_o}, 1);
    check("t6_cpu_rel", {31'd0, cpu_rst_o}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
